// File: rtl/rr_arb_pkg.sv
// Shared types and sizing helpers for the round-robin grant arbiter.
package rr_arb_pkg;

  // Arbiter FSM: IDLE has no owner, BUSY holds exactly one grant.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_leave_one_hot.sv
// Keeps only the lowest set bit of a vector; all-zero in gives all-zero out.
module leave_one_hot #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [WIDTH-1:0] out_vec
);

  // Two's-complement trick isolates the least significant one.
  assign out_vec = in_vec & (~in_vec + WIDTH'(1));

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with registered one-hot grant and hold limit.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 256
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [WIDTH-1:0]            req,
  input  logic                        release_pulse,
  output logic [WIDTH-1:0]            grant,
  output logic                        grant_valid,
  output logic [idx_width(WIDTH)-1:0] grant_idx,
  output logic                        timeout
);

  localparam int IDXW  = idx_width(WIDTH);
  localparam int HOLDW = idx_width(MAX_HOLD + 1);
  localparam logic [HOLDW-1:0] HOLD_LIM = (MAX_HOLD == 0) ? {HOLDW{1'b0}} : HOLDW'(MAX_HOLD - 1);
  localparam logic [HOLDW-1:0] HOLD_SAT = {HOLDW{1'b1}};
  localparam logic [IDXW-1:0]  PTR_RST  = IDXW'(WIDTH - 1);

  arb_state_e       state_q, state_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [HOLDW-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IDXW-1:0]  grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic             timeout_q, timeout_d;
  // Blocks granting on the first edge after reset deassertion.
  logic             armed_q, armed_d;

  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] masked_req_s;
  logic [WIDTH-1:0] masked_oh_s;
  logic [WIDTH-1:0] unmasked_oh_s;
  logic [WIDTH-1:0] win_oh_s;
  logic [IDXW-1:0]  win_idx_s;
  logic             req_any_s;
  logic             limit_hit_s;

  // Priority mask: only requesters strictly above the last winner.
  always_comb begin
    mask_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      mask_s[i] = (IDXW'(i) > ptr_q);
    end
  end

  assign masked_req_s = req & mask_s;
  assign req_any_s    = |req;

  leave_one_hot #(.WIDTH(WIDTH)) u_loh_masked (
    .in_vec  (masked_req_s),
    .out_vec (masked_oh_s)
  );

  leave_one_hot #(.WIDTH(WIDTH)) u_loh_unmasked (
    .in_vec  (req),
    .out_vec (unmasked_oh_s)
  );

  // Pick the wrapped-around winner and encode it to a binary index.
  always_comb begin
    win_oh_s  = (|masked_req_s) ? masked_oh_s : unmasked_oh_s;
    win_idx_s = {IDXW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      win_idx_s = win_idx_s | ({IDXW{win_oh_s[i]}} & IDXW'(i));
    end
  end

  // Hold limit reached this cycle; disabled entirely when MAX_HOLD is zero.
  assign limit_hit_s = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);

  // Next-state, grant update, pointer update and hold counting.
  // The owner's own bit needs no explicit exclusion on release: ptr equals
  // the owner in BUSY, so it wins again only when nobody else requests.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_d        = hold_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    armed_d       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && req_any_s) begin
          state_d       = ST_BUSY;
          grant_d       = win_oh_s;
          grant_idx_d   = win_idx_s;
          grant_valid_d = 1'b1;
          ptr_d         = win_idx_s;
          hold_d        = {HOLDW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (release_pulse || limit_hit_s) begin
          timeout_d = ~release_pulse;
          if (req_any_s) begin
            state_d       = ST_BUSY;
            grant_d       = win_oh_s;
            grant_idx_d   = win_idx_s;
            grant_valid_d = 1'b1;
            ptr_d         = win_idx_s;
            hold_d        = {HOLDW{1'b0}};
          end else begin
            state_d       = ST_IDLE;
            grant_d       = {WIDTH{1'b0}};
            grant_idx_d   = {IDXW{1'b0}};
            grant_valid_d = 1'b0;
            hold_d        = {HOLDW{1'b0}};
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLDW'(1);
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_d       = {WIDTH{1'b0}};
        grant_idx_d   = {IDXW{1'b0}};
        grant_valid_d = 1'b0;
        hold_d        = {HOLDW{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= PTR_RST;
      hold_q        <= {HOLDW{1'b0}};
      grant_q       <= {WIDTH{1'b0}};
      grant_idx_q   <= {IDXW{1'b0}};
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      armed_q       <= armed_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign timeout     = timeout_q;

endmodule
